// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store unit facing the external data-memory bus.
// Converts core load/store requests into byte-enabled word requests, stalls
// the core until the access completes, replicates store data across byte
// lanes and extracts and extends load data from the registered read word.
//
// Optional build macro: LSU_MISALIGN_CHECK_EN
//   defined   -> misaligned H/HU/W requests are refused in IDLE with a
//                one-cycle core_misalign_o pulse and no bus request.
//   undefined -> core_misalign_o is tied 0; misaligned accesses are issued
//                with truncated byte lanes (H) or an ignored offset (W).
module lsu_mem_initiator #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_stall_o,
    output logic              core_misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    input  logic              mem_ready_i
);

    // funct3 size codes; 3, 6 and 7 are undefined and behave as a word
    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic        we_q;

    logic        req_misaligned;
    logic        issue;
    logic [3:0]  be_calc;
    logic [31:0] wd_calc;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // Misalignment detection; undefined size codes are never flagged
`ifdef LSU_MISALIGN_CHECK_EN
    assign req_misaligned = core_req_i &&
        ((((core_size_i == SZ_H) || (core_size_i == SZ_HU)) && core_addr_i[0]) ||
         ((core_size_i == SZ_W) && (core_addr_i[1:0] != 2'b00)));
`else
    assign req_misaligned = 1'b0;
`endif

    // A bus request is live while the core asks in IDLE or while waiting
    assign issue = ((state_q == ST_IDLE) && core_req_i && !req_misaligned) ||
                   (state_q == ST_WAIT);

    // Byte-lane enables and lane-replicated store data from the core request
    always_comb begin
        case (core_size_i)
            SZ_B, SZ_BU: begin
                be_calc = 4'b0001 << core_addr_i[1:0];
                wd_calc = {4{core_wd_i[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be_calc = 4'b0011 << {core_addr_i[1], 1'b0};
                wd_calc = {2{core_wd_i[15:0]}};
            end
            default: begin
                be_calc = 4'b1111;
                wd_calc = core_wd_i;
            end
        endcase
    end

    // Extract and extend load data using the offset and size latched at acceptance
    always_comb begin
        byte_sel = mem_rd_i[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_q)
            SZ_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   load_data = {24'h0, byte_sel};
            SZ_H:    load_data = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   load_data = {16'h0, half_sel};
            default: load_data = mem_rd_i;
        endcase
    end

    // Access sequencing: IDLE -> (WAIT) -> DONE -> IDLE, latching the access fields on acceptance
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            off_q   <= 2'b00;
            size_q  <= 3'd0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (core_req_i && !req_misaligned) begin
                        if (mem_ready_i) begin
                            off_q   <= core_addr_i[1:0];
                            size_q  <= core_size_i;
                            we_q    <= core_we_i;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ready_i) begin
                        off_q   <= core_addr_i[1:0];
                        size_q  <= core_size_i;
                        we_q    <= core_we_i;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output decode; everything is held at 0 while reset is asserted
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        core_rd_o       = '0;
        core_stall_o    = 1'b0;
        core_misalign_o = 1'b0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_be_o        = 4'b0000;
        mem_addr_o      = '0;
        mem_wd_o        = '0;
        if (!rst_i) begin
            mem_addr_o   = core_addr_i;
            mem_req_o    = issue;
            core_stall_o = issue;
            if (state_q == ST_IDLE) begin
                core_misalign_o = req_misaligned;
            end
            if ((state_q == ST_DONE) && !we_q) begin
                core_rd_o = load_data;
            end
            if (issue) begin
                mem_we_o = core_we_i;
                mem_be_o = be_calc;
                mem_wd_o = wd_calc;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: a directed vector table from the
// worked examples, hand sequences for wait states, reset mid-access and
// misalignment, then randomized accesses checked against a byte-addressed
// reference model of memory.
module tb_lsu_mem_initiator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int checks = 0;
    int errors = 0;

    // Bus-side memory (word array, 256 bytes) and the reference byte image
    logic [31:0] bus_mem [0:63];
    logic [7:0]  ref_mem [0:255];

    lsu_mem_initiator #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .core_req_i      (core_req_i),
        .core_we_i       (core_we_i),
        .core_size_i     (core_size_i),
        .core_addr_i     (core_addr_i),
        .core_wd_i       (core_wd_i),
        .core_rd_o       (core_rd_o),
        .core_stall_o    (core_stall_o),
        .core_misalign_o (core_misalign_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wd_o        (mem_wd_o),
        .mem_rd_i        (mem_rd_i),
        .mem_ready_i     (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory slave: byte-enabled writes, read data registered one cycle after acceptance
    always @(posedge clk_i) begin
        if (!rst_i && mem_req_o && mem_ready_i) begin
            if (mem_we_o) begin
                for (int l = 0; l < 4; l++) begin
                    if (mem_be_o[l]) bus_mem[mem_addr_o[7:2]][8*l +: 8] <= mem_wd_o[8*l +: 8];
                end
            end else begin
                mem_rd_i <= bus_mem[mem_addr_o[7:2]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One complete access: request cycle(s), then the DONE cycle
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                          input logic exp_flag);
        step();
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        if (exp_flag) begin
            mem_ready_i = 1'b1;
            #2;
            check("flag_misalign", core_misalign_o, 32'd1);
            check("flag_req", mem_req_o, 32'd0);
            check("flag_stall", core_stall_o, 32'd0);
            core_req_i = 1'b0;
            return;
        end
        for (int c = 0; c <= waits; c++) begin
            if (c > 0) step();
            mem_ready_i = (c == waits);
            #2;
            check("req", mem_req_o, 32'd1);
            check("stall", core_stall_o, 32'd1);
            check("addr", mem_addr_o, addr);
            check("we", mem_we_o, we);
            check("be", mem_be_o, exp_be);
            if (we) check("wd", mem_wd_o, exp_wd);
            check("misalign_low", core_misalign_o, 32'd0);
        end
        step();
        core_req_i  = 1'b0;
        mem_ready_i = 1'($urandom_range(0, 1));
        #2;
        check("done_req", mem_req_o, 32'd0);
        check("done_stall", core_stall_o, 32'd0);
        check("done_be", mem_be_o, 32'd0);
        check("done_wd", mem_wd_o, 32'd0);
        check("done_rd", core_rd_o, exp_rd);
    endtask

    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic flagged(input logic [2:0] s, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        return (((s == 3'd1) || (s == 3'd5)) && a[0]) || ((s == 3'd2) && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic        r_we;
        logic [2:0]  r_size;
        logic [31:0] r_addr, r_wd, r_mwd, r_rd, base;
        logic [3:0]  r_be;
        logic        r_fl;
        int          nb;

        vecs[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 3'd2, 32'h10, 32'h00112233, 4'hF, 32'h00112233, 32'h0};
        vecs[2]  = '{1'b1, 3'd0, 32'h13, 32'h000000A5, 4'h8, 32'hA5A5A5A5, 32'h0};
        vecs[3]  = '{1'b0, 3'd2, 32'h10, 32'h0,        4'hF, 32'h0,        32'hA5112233};
        vecs[4]  = '{1'b1, 3'd2, 32'h20, 32'h80F17F01, 4'hF, 32'h80F17F01, 32'h0};
        vecs[5]  = '{1'b0, 3'd0, 32'h23, 32'h0,        4'h8, 32'h0,        32'hFFFFFF80};
        vecs[6]  = '{1'b0, 3'd4, 32'h23, 32'h0,        4'h8, 32'h0,        32'h00000080};
        vecs[7]  = '{1'b0, 3'd1, 32'h22, 32'h0,        4'hC, 32'h0,        32'hFFFF80F1};
        vecs[8]  = '{1'b0, 3'd5, 32'h20, 32'h0,        4'h3, 32'h0,        32'h00007F01};
        vecs[9]  = '{1'b1, 3'd1, 32'h26, 32'h1234BEEF, 4'hC, 32'hBEEFBEEF, 32'h0};
        vecs[10] = '{1'b0, 3'd3, 32'h21, 32'h0,        4'hF, 32'h0,        32'h80F17F01};

        for (int i = 0; i < 64; i++) bus_mem[i] = 32'h0;
        mem_rd_i = 32'h0;

        // Reset with an active request: all outputs must be forced low
        rst_i       = 1'b1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b1;
        core_size_i = 3'd2;
        core_addr_i = 32'h20;
        core_wd_i   = 32'hFFFFFFFF;
        mem_ready_i = 1'b1;
        step();
        step();
        check("rst_req", mem_req_o, 32'd0);
        check("rst_stall", core_stall_o, 32'd0);
        check("rst_we", mem_we_o, 32'd0);
        check("rst_be", mem_be_o, 32'd0);
        check("rst_wd", mem_wd_o, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_rd", core_rd_o, 32'd0);
        step();
        rst_i      = 1'b0;
        core_req_i = 1'b0;
        #2;
        check("idle_stall", core_stall_o, 32'd0);
        check("idle_req", mem_req_o, 32'd0);
        check("idle_rd", core_rd_o, 32'd0);

        // Directed vectors, ready tied high (2-cycle accesses)
        for (int i = 0; i < 11; i++) begin
            access(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd, 0,
                   vecs[i].be, vecs[i].mwd, vecs[i].rd, 1'b0);
        end

        // Wait states: ready low for 3 cycles -> stall for 4 cycles with stable request
        access(1'b0, 3'd2, 32'h20, 32'h0, 3, 4'hF, 32'h0, 32'h80F17F01, 1'b0);

        // Reset while in WAIT aborts the access with no DONE cycle
        step();
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h20;
        mem_ready_i = 1'b0;
        #2;
        check("wait_stall", core_stall_o, 32'd1);
        step();
        rst_i = 1'b1;
        #2;
        check("rstw_req", mem_req_o, 32'd0);
        check("rstw_stall", core_stall_o, 32'd0);
        check("rstw_addr", mem_addr_o, 32'd0);
        check("rstw_be", mem_be_o, 32'd0);
        step();
        rst_i       = 1'b0;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b1;
        #2;
        check("rstw_after_stall", core_stall_o, 32'd0);
        check("rstw_after_rd", core_rd_o, 32'd0);

        // Misaligned SW at 0x11
`ifdef LSU_MISALIGN_CHECK_EN
        access(1'b1, 3'd2, 32'h11, 32'h55667788, 0, 4'hF, 32'h0, 32'h0, 1'b1);
        access(1'b0, 3'd2, 32'h10, 32'h0, 0, 4'hF, 32'h0, 32'hA5112233, 1'b0);
`else
        access(1'b1, 3'd2, 32'h11, 32'h55667788, 0, 4'hF, 32'h55667788, 32'h0, 1'b0);
        access(1'b0, 3'd2, 32'h10, 32'h0, 0, 4'hF, 32'h0, 32'h55667788, 1'b0);
`endif

        // Randomized accesses against the byte-level reference model
        for (int i = 0; i < 64; i++) bus_mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
        for (int n = 0; n < 300; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_size = 3'($urandom_range(0, 7));
            r_addr = 32'($urandom_range(0, 255));
            r_wd   = $urandom;
            nb     = nbytes(r_size);
            base   = r_addr & ~(32'(nb) - 32'd1);
            r_be   = 4'b0000;
            r_mwd  = 32'h0;
            r_rd   = 32'h0;
            for (int k = 0; k < nb; k++) r_be[(base + 32'(k)) % 4] = 1'b1;
            for (int l = 0; l < 4; l++) r_mwd[8*l +: 8] = r_wd[8*(l % nb) +: 8];
            if (!r_we) begin
                for (int k = 0; k < nb; k++) r_rd = r_rd | ({24'h0, ref_mem[base + 32'(k)]} << (8*k));
                if (((r_size == 3'd0) || (r_size == 3'd1)) && r_rd[8*nb-1]) r_rd = r_rd | (32'hFFFFFFFF << (8*nb));
            end
            r_fl = flagged(r_size, r_addr);
            access(r_we, r_size, r_addr, r_wd, $urandom_range(0, 2), r_be, r_mwd, r_rd, r_fl);
            if (r_we && !r_fl) begin
                for (int k = 0; k < nb; k++) ref_mem[base + 32'(k)] = r_wd[8*k +: 8];
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
